memristor_puf_controller: RTL and testbench
===========================================

// Module: memristor_puf_controller
// PURPOSE
//  Sequences a memristor pair (two memristor_conductance instances, A and B) to evaluate a PUF challenge.
//  Per challenge bit: drives opposing program pulses onto vin_a/vin_b, lets G settle, then compares g_a vs g_b.
//  The comparison gives one response bit. Sits between the challenge source and the two memristor cells.
// PARAMETERS
//  CH_BITS   8        challenge/response width (>=1)
//  WIDTH     32       conductance width, matches memristor G
//  VPROG     8'sd40   program pulse magnitude, signed 8-bit; must be >= cell VTH and <= 127
//  PULSE_CYC 4        cycles each program pulse is held (>=1)
// PORTS
//  clk        in   1        rising-edge clock
//  reset_n    in   1        asynchronous, active-low reset
//  start      in   1        request evaluation; sampled only in IDLE
//  challenge  in   CH_BITS  challenge word, latched when start is accepted
//  busy       out  1        high from accept until the final compare
//  done       out  1        one-cycle pulse; response valid from this cycle
//  response   out  CH_BITS  response word, held until next accepted start
//  tie        out  1        sticky: some compare saw g_a == g_b (see CONFIGURATION)
//  cell_rst   out  1        drives memristor reset (active-high, synchronous in cell)
//  vin_a      out  8 (s)    signed pulse to cell A
//  vin_b      out  8 (s)    signed pulse to cell B
//  g_a        in   WIDTH    conductance of cell A, unsigned
//  g_b        in   WIDTH    conductance of cell B, unsigned
// BEHAVIOUR
//  Reset (reset_n=0, async):
//   - state=IDLE; busy=0, done=0, response=0, tie=0, vin_a=vin_b=0
//   - cell_rst=1: cells initialise on the clock edges while reset is held; cell_rst clears on the first clk after release.
//  All outputs are registered. States are IDLE, CRST, PROG, SETTLE, CMP, DONE.
//  IDLE:
//   - start=1 -> CRST; latch challenge; response<=0; tie<=0; bit index<=CH_BITS-1.
//   - start=0 -> stay in IDLE.
//  CRST (1 cycle): cell_rst=1, busy=1; -> PROG with pulse counter=0.
//  PROG (PULSE_CYC cycles), cell_rst=0:
//   - challenge[idx]=1: vin_a=+VPROG, vin_b=-VPROG.
//   - challenge[idx]=0: vin_a=-VPROG, vin_b=+VPROG.
//   - Counter reaching PULSE_CYC-1 -> SETTLE.
//  SETTLE (1 cycle): vin_a=vin_b=0, which absorbs the cell's 1-cycle G register latency; -> CMP.
//  CMP (1 cycle), vins=0:
//   - response[idx] <= (g_a > g_b), unsigned compare; equality gives 0.
//   - idx==0 -> DONE; else idx-- and -> PROG.
//  DONE (1 cycle): done=1, busy=0; -> IDLE. A start in this cycle is ignored.
//  Timing:
//   - accept edge to done = 1 + CH_BITS*(PULSE_CYC+2) + 1 cycles.
//   - busy spans CRST..last CMP.
//  start while busy or done is ignored. challenge is not re-sampled mid-run.
//  Bit order is MSB first. Cells accumulate across bits and are reset only in CRST.
//  reset_n asserted mid-run: immediate abort to the reset values above. No done pulse; response is cleared.
//  Counters use $clog2-sized fields (min 1 bit). The index never underflows: the DONE branch is taken at idx==0.
// CONFIGURATION
//  MPUF_TIE_DETECT_EN defined:
//   - In CMP, g_a==g_b sets tie<=1. tie is sticky until the next accepted start or reset.
//  Undefined: tie is held constant 0; no compare-equality logic is built.
// TESTING (bench models g_a/g_b directly; CH_BITS=4, PULSE_CYC=2, VPROG=40)
//  1. Release reset -> cell_rst=1 until the first edge, then 0. All other outputs stay at reset values. vins=0.
//  2. start=1, challenge=4'b1010 ->
//   - cell_rst for 1 cycle.
//   - vin_a=+40 / vin_b=-40 for 2 cycles on bit3, then the pattern reverses for bit2, and so on.
//   - done exactly 18 cycles after the accept edge.
//  3. Bench holds g_a=500, g_b=100 on bits 3 and 1, and g_a=100, g_b=500 on bits 2 and 0 -> response=4'b1010 at done.
//  4. g_a=g_b=300 on bit 2 -> response[2]=0.
//   - With MPUF_TIE_DETECT_EN: tie=1 at done, cleared by the next start.
//   - Without it: tie stays 0.
//  5. start pulsed during PROG and again in DONE -> ignored; exactly one done pulse; next run needs start in IDLE.
//  6. reset_n low during bit 1 CMP -> next cycle busy=0, response=0, vins=0, cell_rst=1; no done pulse seen.

Source files
------------

// File: rtl/memristor_puf_controller.sv
// Memristor-pair PUF sequencer: program, settle, compare per challenge bit, MSB first; MPUF_TIE_DETECT_EN adds sticky tie flag.
// Latency 1 + CH_BITS*(PULSE_CYC+2) + 1 cycles incl. DONE; start is ignored unless IDLE (no queueing).
module memristor_puf_controller #(
  parameter int                 CH_BITS   = 8,
  parameter int                 WIDTH     = 32,
  parameter logic signed [7:0]  VPROG     = 8'sd40,
  parameter int                 PULSE_CYC = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [CH_BITS-1:0]  challenge,
  output logic                busy,
  output logic                done,
  output logic [CH_BITS-1:0]  response,
  output logic                tie,
  output logic                cell_rst,
  output logic signed [7:0]   vin_a,
  output logic signed [7:0]   vin_b,
  input  logic [WIDTH-1:0]    g_a,
  input  logic [WIDTH-1:0]    g_b
);

  localparam int IW = (CH_BITS > 1) ? $clog2(CH_BITS) : 1;
  localparam int CW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
  localparam logic [IW-1:0] IDX_TOP  = IW'(CH_BITS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PULSE_CYC - 1);
  localparam logic signed [7:0] VNEG = -VPROG;

  typedef enum logic [2:0] {IDLE, CRST, PROG, SETTLE, CMP, DONE} state_t;

  state_t             state;
  logic [CH_BITS-1:0] ch;
  logic [IW-1:0]      idx;
  logic [CW-1:0]      cnt;
  logic [IW-1:0]      idx_dec;
  logic               bit_cur;
  logic               bit_nxt;

  assign idx_dec = idx - 1'b1;
  assign bit_cur = ch[idx];
  assign bit_nxt = ch[idx_dec];

`ifdef MPUF_TIE_DETECT_EN
  logic tie_q;
  assign tie = tie_q;
`else
  assign tie = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      response <= '0;
      cell_rst <= 1'b1;
      vin_a    <= '0;
      vin_b    <= '0;
      ch       <= '0;
      idx      <= '0;
      cnt      <= '0;
`ifdef MPUF_TIE_DETECT_EN
      tie_q    <= 1'b0;
`endif
    end else begin
      done     <= 1'b0;
      cell_rst <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= CRST;
            ch       <= challenge;
            response <= '0;
            idx      <= IDX_TOP;
            busy     <= 1'b1;
            cell_rst <= 1'b1;
`ifdef MPUF_TIE_DETECT_EN
            tie_q    <= 1'b0;
`endif
          end
        end
        CRST: begin
          state <= PROG;
          cnt   <= '0;
          vin_a <= bit_cur ? VPROG : VNEG;
          vin_b <= bit_cur ? VNEG  : VPROG;
        end
        PROG: begin
          if (cnt == CNT_LAST) begin
            state <= SETTLE;
            vin_a <= '0;
            vin_b <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // SETTLE covers the cell's one-cycle G register delay before sampling
        SETTLE: state <= CMP;
        CMP: begin
          response[idx] <= (g_a > g_b);
`ifdef MPUF_TIE_DETECT_EN
          if (g_a == g_b) tie_q <= 1'b1;
`endif
          if (idx == '0) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            idx   <= idx_dec;
            cnt   <= '0;
            state <= PROG;
            vin_a <= bit_nxt ? VPROG : VNEG;
            vin_b <= bit_nxt ? VNEG  : VPROG;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memristor_puf_controller.sv
// Directed bench for memristor_puf_controller (CH_BITS=4, PULSE_CYC=2, VPROG=40); g_a/g_b driven per bit.
module tb_memristor_puf_controller;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [3:0]        challenge;
  logic              busy;
  logic              done;
  logic [3:0]        response;
  logic              tie;
  logic              cell_rst;
  logic signed [7:0] vin_a;
  logic signed [7:0] vin_b;
  logic [31:0]       g_a;
  logic [31:0]       g_b;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  memristor_puf_controller #(
    .CH_BITS(4), .WIDTH(32), .VPROG(8'sd40), .PULSE_CYC(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .challenge(challenge),
    .busy(busy), .done(done), .response(response), .tie(tie),
    .cell_rst(cell_rst), .vin_a(vin_a), .vin_b(vin_b), .g_a(g_a), .g_b(g_b)
  );

`ifdef MPUF_TIE_DETECT_EN
  localparam logic TIE_ON = 1'b1;
`else
  localparam logic TIE_ON = 1'b0;
`endif

  // Cycle c counts from the accept edge: c=1 CRST, c=2..17 bits 3..0 (PROG,PROG,SETTLE,CMP), c=18 DONE.
  task automatic run_challenge(input string name, input logic [3:0] ch,
                               input logic [3:0][31:0] ga, input logic [3:0][31:0] gb,
                               input logic [3:0] exp_resp, input logic exp_tie,
                               input bit extra, input int abort_cyc);
    int d0;
    bit aborted;
    logic signed [7:0] exp_va;
    logic exp_busy, exp_done, exp_crst;
    aborted = 1'b0;
    challenge = ch;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    d0 = done_cnt;
    for (int c = 1; c <= 22; c++) begin
      if (c == abort_cyc) begin
        reset_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s abort busy got %b want 0", name, busy); end
        total++; if (response !== 4'b0) begin bad++; $display("FAIL %s abort response got %b want 0000", name, response); end
        total++; if (vin_a !== 8'sd0 || vin_b !== 8'sd0) begin bad++; $display("FAIL %s abort vins got %0d/%0d want 0/0", name, vin_a, vin_b); end
        total++; if (cell_rst !== 1'b1) begin bad++; $display("FAIL %s abort cell_rst got %b want 1", name, cell_rst); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (done_cnt != d0) begin bad++; $display("FAIL %s abort done pulses got %0d want 0", name, done_cnt - d0); end
        total++; if (cell_rst !== 1'b1) begin bad++; $display("FAIL %s abort held cell_rst got %b want 1", name, cell_rst); end
        reset_n = 1'b1;
        @(posedge clk); #1;
        total++; if (cell_rst !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL %s post-abort cell_rst/busy got %b/%b want 0/0", name, cell_rst, busy); end
        aborted = 1'b1;
        break;
      end
      exp_busy = (c >= 1 && c <= 17);
      exp_done = (c == 18);
      exp_crst = (c == 1);
      exp_va   = 8'sd0;
      if (c >= 2 && c <= 17) begin
        int j, ph, b;
        j  = (c - 2) / 4;
        ph = (c - 2) % 4;
        b  = 3 - j;
        if (ph < 2) exp_va = ch[b] ? 8'sd40 : -8'sd40;
        if (ph == 0) begin g_a = ga[b]; g_b = gb[b]; end
      end
      total++; if (busy !== exp_busy) begin bad++; $display("FAIL %s c%0d busy got %b want %b", name, c, busy, exp_busy); end
      total++; if (done !== exp_done) begin bad++; $display("FAIL %s c%0d done got %b want %b", name, c, done, exp_done); end
      total++; if (cell_rst !== exp_crst) begin bad++; $display("FAIL %s c%0d cell_rst got %b want %b", name, c, cell_rst, exp_crst); end
      total++; if (vin_a !== exp_va) begin bad++; $display("FAIL %s c%0d vin_a got %0d want %0d", name, c, vin_a, exp_va); end
      total++; if (vin_b !== -exp_va) begin bad++; $display("FAIL %s c%0d vin_b got %0d want %0d", name, c, vin_b, -exp_va); end
      if (c == 1) begin
        total++; if (response !== 4'b0 || tie !== 1'b0) begin bad++; $display("FAIL %s accept clear response/tie got %b/%b want 0000/0", name, response, tie); end
      end
      if (c == 18) begin
        total++; if (response !== exp_resp) begin bad++; $display("FAIL %s response got %b want %b", name, response, exp_resp); end
        total++; if (tie !== exp_tie) begin bad++; $display("FAIL %s tie got %b want %b", name, tie, exp_tie); end
      end
      if (extra) begin
        if (c == 2 || c == 18) start = 1'b1;
        if (c == 3 || c == 19) start = 1'b0;
      end
      @(posedge clk); #1;
    end
    if (!aborted) begin
      total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL %s done pulse count got %0d want 1", name, done_cnt - d0); end
      total++; if (response !== exp_resp) begin bad++; $display("FAIL %s held response got %b want %b", name, response, exp_resp); end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; challenge = 4'h0; g_a = '0; g_b = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset done got %b want 0", done); end
    total++; if (response !== 4'b0) begin bad++; $display("FAIL reset response got %b want 0000", response); end
    total++; if (tie !== 1'b0) begin bad++; $display("FAIL reset tie got %b want 0", tie); end
    total++; if (cell_rst !== 1'b1) begin bad++; $display("FAIL reset cell_rst got %b want 1", cell_rst); end
    total++; if (vin_a !== 8'sd0 || vin_b !== 8'sd0) begin bad++; $display("FAIL reset vins got %0d/%0d want 0/0", vin_a, vin_b); end
    reset_n = 1'b1;
    #1;
    total++; if (cell_rst !== 1'b1) begin bad++; $display("FAIL release cell_rst before edge got %b want 1", cell_rst); end
    @(posedge clk); #1;
    total++; if (cell_rst !== 1'b0) begin bad++; $display("FAIL release cell_rst after edge got %b want 0", cell_rst); end
    total++; if (busy !== 1'b0 || done !== 1'b0 || vin_a !== 8'sd0) begin bad++; $display("FAIL release idle busy/done/vin_a got %b/%b/%0d want 0/0/0", busy, done, vin_a); end
  endtask

  task automatic test_response();
    run_challenge("resp", 4'b1010, {32'd500, 32'd100, 32'd500, 32'd100},
                  {32'd100, 32'd500, 32'd100, 32'd500}, 4'b1010, 1'b0, 1'b0, 0);
  endtask

  task automatic test_tie();
    run_challenge("tie", 4'b0100, {32'd500, 32'd300, 32'd500, 32'd100},
                  {32'd100, 32'd300, 32'd100, 32'd500}, 4'b1010, TIE_ON, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    run_challenge("ignore_start", 4'b0011, {32'd100, 32'd100, 32'd100, 32'd500},
                  {32'd500, 32'd500, 32'd500, 32'd100}, 4'b0001, 1'b0, 1'b1, 0);
  endtask

  task automatic test_abort();
    run_challenge("abort", 4'b1010, {32'd500, 32'd100, 32'd500, 32'd100},
                  {32'd100, 32'd500, 32'd100, 32'd500}, 4'b1010, 1'b0, 1'b0, 13);
  endtask

  initial begin
    test_reset();
    test_response();
    test_tie();
    test_back_to_back();
    test_abort();
    test_response();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
